// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Round-robin successor of the releasing holder, wrapping at num_req
    // (works for non-power-of-two producer counts).
    function automatic int unsigned next_rr_ptr(input int unsigned holder,
                                                input int unsigned num_req);
        return (holder + 1 >= num_req) ? 0 : holder + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer and FIFO write-side signals of the write-port arbiter.
// slave: the arbiter; master: producers, FIFO and control that drive it.
interface fifo_wr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_full;
    logic                           fifo_wr_en;
    logic [DATA_W-1:0]              fifo_wr_data;
    logic                           gnt_valid;
    logic [IDX_W-1:0]               gnt_id;
    logic                           err_overlen;
    logic                           err_clr;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full, err_clr,
        output req_ready, fifo_wr_en, fifo_wr_data, gnt_valid, gnt_id, err_overlen
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full, err_clr,
        input  req_ready, fifo_wr_en, fifo_wr_data, gnt_valid, gnt_id, err_overlen
    );
endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// Rotating-priority picker: first requester found scanning from rr_ptr upward,
// wrapping modulo NUM_REQ.
module wr_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);
    logic found;

    // Scan offsets 0..NUM_REQ-1 from rr_ptr and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the FIFO write port between
// NUM_REQ producers. One idle cycle between packets; one beat per cycle inside
// a packet; FIFO full stalls the holder without losing its grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int MAX_PKT = 8
) (
    input logic          wr_clk,
    input logic          rst_n,
    fifo_wr_arb_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_PKT + 1);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   gnt_id, gnt_id_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               err_overlen, err_overlen_nxt;

    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [NUM_REQ-1:0] req_ready;
    logic               fifo_wr_en;
    logic [DATA_W-1:0]  fifo_wr_data;

    wr_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next-state, beat counting, release and the write-port mux.
    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        gnt_id_nxt      = gnt_id;
        beat_cnt_nxt    = beat_cnt;
        err_overlen_nxt = err_overlen & ~bus.err_clr;
        req_ready       = '0;
        fifo_wr_en      = 1'b0;
        fifo_wr_data    = '0;

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt    = ARB_BUSY;
                    gnt_id_nxt   = winner;
                    beat_cnt_nxt = '0;
                end
            end
            ARB_BUSY: begin
                req_ready[gnt_id] = !bus.fifo_full;
                fifo_wr_en        = bus.req_valid[gnt_id] & !bus.fifo_full;
                fifo_wr_data      = bus.req_data[gnt_id];
                if (fifo_wr_en) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (bus.req_last[gnt_id] || beat_cnt == CNT_W'(MAX_PKT - 1)) begin
                        // Release on last beat, or cut an overlong packet; setting
                        // the error overrides a simultaneous clear.
                        state_nxt    = ARB_IDLE;
                        rr_ptr_nxt   = IDX_W'(next_rr_ptr(32'(gnt_id), NUM_REQ));
                        beat_cnt_nxt = '0;
                        if (!bus.req_last[gnt_id]) begin
                            err_overlen_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            gnt_id      <= '0;
            beat_cnt    <= '0;
            err_overlen <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gnt_id      <= gnt_id_nxt;
            beat_cnt    <= beat_cnt_nxt;
            err_overlen <= err_overlen_nxt;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.fifo_wr_en   = fifo_wr_en;
    assign bus.fifo_wr_data = fifo_wr_data;
    assign bus.gnt_valid    = (state == ARB_BUSY);
    assign bus.gnt_id       = gnt_id;
    assign bus.err_overlen  = err_overlen;

    // A pending beat must stay put until the arbiter accepts it.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold_chk
        a_hold_stable : assert property (@(posedge wr_clk) disable iff (!rst_n)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
            (bus.req_valid[i] && $stable(bus.req_data[i]) && $stable(bus.req_last[i])));
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// packet-level round-robin model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int MAX_PKT = 4;
    localparam int IDX_W   = 2;
    localparam int LIMIT   = 3000;

    logic wr_clk = 1'b0;
    logic rst_n  = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] wr_log[$];

    // Random-phase stimulus and model state.
    logic [DATA_W-1:0] tx_data[NUM_REQ][$];
    bit                tx_last[NUM_REQ][$];
    int                pos[NUM_REQ];
    int                k3[NUM_REQ];
    int                total_beats;
    int                cyc;
    bit                m_gv;
    int                m_g;
    int                m_rr;
    int                m_cnt;
    bit                m_err;
    bit                exp_wr;
    bit                lst;
    logic [NUM_REQ-1:0] exp_ready;

    fifo_wr_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .wr_clk (wr_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 wr_clk = ~wr_clk;

    // Everything the FIFO accepts, in order.
    always @(posedge wr_clk) begin
        if (bus.fifo_wr_en === 1'b1) wr_log.push_back(bus.fifo_wr_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [DATA_W-1:0] d, input logic l);
        bus.req_valid[i] = v;
        bus.req_data[i]  = d;
        bus.req_last[i]  = l;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        bus.err_clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wr_log.delete();
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int start);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
        end
        return 0;
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        bus.err_clr   = 1'b0;

        // 1: reset state and idle after release
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_gnt_valid", 32'(bus.gnt_valid), 0);
        check("rst_gnt_id", 32'(bus.gnt_id), 0);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("rst_wr_data", 32'(bus.fifo_wr_data), 0);
        check("rst_err", 32'(bus.err_overlen), 0);
        rst_n = 1'b1;
        repeat (3) begin
            #1 check("idle_gnt_valid", 32'(bus.gnt_valid), 0);
            tick();
        end

        // 2: two 2-beat packets from producers 0 and 2
        drive(0, 1'b1, 16'h1000, 1'b0);
        drive(2, 1'b1, 16'h2000, 1'b0);
        #1 check("t2_arb_gnt_valid", 32'(bus.gnt_valid), 0);
        check("t2_arb_wr_en", 32'(bus.fifo_wr_en), 0);
        tick();
        #1 check("t2_gnt_valid", 32'(bus.gnt_valid), 1);
        check("t2_gnt_id0", 32'(bus.gnt_id), 0);
        check("t2_ready0", 32'(bus.req_ready), 32'h1);
        check("t2_wr_data0", 32'(bus.fifo_wr_data), 32'h1000);
        tick();
        drive(0, 1'b1, 16'h1001, 1'b1);
        #1 check("t2_wr_data1", 32'(bus.fifo_wr_data), 32'h1001);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        #1 check("t2_bubble", 32'(bus.gnt_valid), 0);
        check("t2_bubble_wr", 32'(bus.fifo_wr_en), 0);
        tick();
        #1 check("t2_gnt_id2", 32'(bus.gnt_id), 2);
        check("t2_ready2", 32'(bus.req_ready), 32'h4);
        check("t2_wr_data2", 32'(bus.fifo_wr_data), 32'h2000);
        tick();
        drive(2, 1'b1, 16'h2001, 1'b1);
        #1 check("t2_wr_data3", 32'(bus.fifo_wr_data), 32'h2001);
        tick();
        drive(2, 1'b0, 16'h0, 1'b0);
        #1 check("t2_end_gnt", 32'(bus.gnt_valid), 0);
        check("t2_log_size", 32'(wr_log.size()), 4);
        if (wr_log.size() == 4) begin
            check("t2_log0", 32'(wr_log[0]), 32'h1000);
            check("t2_log1", 32'(wr_log[1]), 32'h1001);
            check("t2_log2", 32'(wr_log[2]), 32'h2000);
            check("t2_log3", 32'(wr_log[3]), 32'h2001);
        end

        // 3: all producers, continuous 1-beat packets
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            k3[i] = 0;
            drive(i, 1'b1, 16'(32'h3000 + i * 256), 1'b1);
        end
        for (int p = 0; p < 2 * NUM_REQ; p++) begin
            #1 check("t3_idle", 32'(bus.gnt_valid), 0);
            check("t3_idle_wr", 32'(bus.fifo_wr_en), 0);
            tick();
            #1 check("t3_gnt_id", 32'(bus.gnt_id), 32'(p % NUM_REQ));
            check("t3_wr_en", 32'(bus.fifo_wr_en), 1);
            check("t3_wr_data", 32'(bus.fifo_wr_data),
                  32'h3000 + (p % NUM_REQ) * 256 + k3[p % NUM_REQ]);
            tick();
            k3[p % NUM_REQ]++;
            drive(p % NUM_REQ, 1'b1, 16'(32'h3000 + (p % NUM_REQ) * 256 + k3[p % NUM_REQ]), 1'b1);
        end

        // 4: fifo_full stall on the second beat
        do_reset();
        drive(0, 1'b1, 16'h1000, 1'b0);
        tick();
        #1 check("t4_wr_data0", 32'(bus.fifo_wr_data), 32'h1000);
        tick();
        drive(0, 1'b1, 16'h1001, 1'b1);
        bus.fifo_full = 1'b1;
        repeat (3) begin
            #1 check("t4_stall_wr_en", 32'(bus.fifo_wr_en), 0);
            check("t4_stall_ready", 32'(bus.req_ready), 0);
            check("t4_stall_gnt", 32'(bus.gnt_valid), 1);
            tick();
        end
        bus.fifo_full = 1'b0;
        #1 check("t4_resume_wr_en", 32'(bus.fifo_wr_en), 1);
        check("t4_resume_data", 32'(bus.fifo_wr_data), 32'h1001);
        check("t4_resume_ready", 32'(bus.req_ready), 32'h1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        #1 check("t4_log_size", 32'(wr_log.size()), 2);
        if (wr_log.size() == 2) check("t4_log1", 32'(wr_log[1]), 32'h1001);

        // 5: overlength packet (6 beats, no last), err_clr on the cutting beat
        do_reset();
        drive(1, 1'b1, 16'h5000, 1'b0);
        tick();
        for (int b = 0; b < MAX_PKT; b++) begin
            if (b == MAX_PKT - 1) bus.err_clr = 1'b1;
            #1 check("t5_gnt_id", 32'(bus.gnt_id), 1);
            check("t5_wr_data", 32'(bus.fifo_wr_data), 32'h5000 + b);
            tick();
            drive(1, 1'b1, 16'(32'h5000 + b + 1), 1'b0);
        end
        bus.err_clr = 1'b0;
        #1 check("t5_cut_gnt", 32'(bus.gnt_valid), 0);
        check("t5_err_set", 32'(bus.err_overlen), 1);
        tick();
        #1 check("t5_regrant", 32'(bus.gnt_valid), 1);
        check("t5_wr_data4", 32'(bus.fifo_wr_data), 32'h5004);
        tick();
        drive(1, 1'b1, 16'h5005, 1'b0);
        #1 check("t5_wr_data5", 32'(bus.fifo_wr_data), 32'h5005);
        tick();
        drive(1, 1'b0, 16'h0, 1'b0);
        #1 check("t5_hold_gnt", 32'(bus.gnt_valid), 1);
        check("t5_hold_wr_en", 32'(bus.fifo_wr_en), 0);
        check("t5_err_sticky", 32'(bus.err_overlen), 1);
        check("t5_log_size", 32'(wr_log.size()), 6);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        #1 check("t5_err_clr", 32'(bus.err_overlen), 0);

        // 6: async reset mid-packet, then producer 0 has top priority
        do_reset();
        drive(0, 1'b1, 16'h6000, 1'b1);
        tick();
        #1 check("t6_gnt0", 32'(bus.gnt_id), 0);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b1, 16'h6100, 1'b0);
        tick();
        #1 check("t6_gnt1", 32'(bus.gnt_id), 1);
        check("t6_wr_6100", 32'(bus.fifo_wr_data), 32'h6100);
        tick();
        drive(1, 1'b1, 16'h6101, 1'b1);
        drive(0, 1'b1, 16'h6001, 1'b1);
        #1 check("t6_pre_rst_wr_en", 32'(bus.fifo_wr_en), 1);
        #1 rst_n = 1'b0;
        #1 check("t6_rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("t6_rst_ready", 32'(bus.req_ready), 0);
        check("t6_rst_gnt", 32'(bus.gnt_valid), 0);
        tick();
        rst_n = 1'b1;
        #1 check("t6_post_idle", 32'(bus.gnt_valid), 0);
        tick();
        #1 check("t6_post_gnt_id", 32'(bus.gnt_id), 0);
        check("t6_post_wr_data", 32'(bus.fifo_wr_data), 32'h6001);
        tick();
        drive(0, 1'b0, 16'h0, 1'b0);
        tick();
        #1 check("t6_next_gnt_id", 32'(bus.gnt_id), 1);
        check("t6_next_wr_data", 32'(bus.fifo_wr_data), 32'h6101);
        tick();
        drive(1, 1'b0, 16'h0, 1'b0);

        // 7: randomized packets, random fifo_full, packet-level reference model
        do_reset();
        total_beats = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int seq;
            seq = 0;
            pos[i] = 0;
            tx_data[i].delete();
            tx_last[i].delete();
            repeat ($urandom_range(3, 5)) begin
                int len;
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++) begin
                    tx_data[i].push_back(16'((i << 12) | seq));
                    tx_last[i].push_back(b == len - 1);
                    seq++;
                    total_beats++;
                end
            end
        end
        m_gv = 1'b0; m_g = 0; m_rr = 0; m_cnt = 0; m_err = 1'b0;
        cyc = 0;
        while (cyc < LIMIT && (m_gv || pos[0] < tx_data[0].size() || pos[1] < tx_data[1].size() ||
               pos[2] < tx_data[2].size() || pos[3] < tx_data[3].size())) begin
            bus.fifo_full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i] && pos[i] < tx_data[i].size() && $urandom_range(0, 3) != 0)
                    drive(i, 1'b1, tx_data[i][pos[i]], tx_last[i][pos[i]]);
            end
            #1;
            exp_wr    = m_gv && bus.req_valid[m_g] && !bus.fifo_full;
            exp_ready = (m_gv && !bus.fifo_full) ? NUM_REQ'(1 << m_g) : '0;
            check("rnd_gnt_valid", 32'(bus.gnt_valid), 32'(m_gv));
            if (m_gv) check("rnd_gnt_id", 32'(bus.gnt_id), 32'(m_g));
            check("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("rnd_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
            if (exp_wr) check("rnd_wr_data", 32'(bus.fifo_wr_data), 32'(tx_data[m_g][pos[m_g]]));
            else if (!m_gv) check("rnd_wr_data_idle", 32'(bus.fifo_wr_data), 0);
            check("rnd_err", 32'(bus.err_overlen), 32'(m_err));
            tick();
            cyc++;
            if (m_gv) begin
                if (exp_wr) begin
                    lst = tx_last[m_g][pos[m_g]];
                    pos[m_g]++;
                    m_cnt++;
                    drive(m_g, 1'b0, '0, 1'b0);
                    if (lst || m_cnt == MAX_PKT) begin
                        if (!lst) m_err = 1'b1;
                        m_gv = 1'b0;
                        m_rr = (m_g + 1) % NUM_REQ;
                    end
                end
            end else if (bus.req_valid != '0) begin
                m_gv  = 1'b1;
                m_g   = rr_pick(bus.req_valid, m_rr);
                m_cnt = 0;
            end
        end
        check("rnd_timeout", 32'(cyc < LIMIT), 1);
        check("rnd_total_writes", 32'(wr_log.size()), 32'(total_beats));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
